// File: rtl/uart_rx_fifo_engine.sv
// UART receive engine: 5..DATA_W data bits, optional parity, FWFT result FIFO.
// Define UART_RX_BREAK_EN to add break detection and the o_brk pulse output.
module uart_rx_fifo_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  input  logic [DIV_W-1:0]  i_baud_div,
  input  logic [1:0]        i_nbits,
  input  logic              i_pen,
  input  logic              i_ohel,
  input  logic              i_read,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_perr,
  output logic              o_ferr,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_ovf,
  output logic              o_intr
`ifdef UART_RX_BREAK_EN
  ,
  output logic              o_brk
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam int EW = DATA_W + 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Receiver state
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        nbits_q, nbits_d;
  logic              pen_q, pen_d;
  logic              ohel_q, ohel_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_q, perr_d;
`ifdef UART_RX_BREAK_EN
  logic              zero_q, zero_d;
  logic              brk_wait_q, brk_wait_d;
  logic              brk;
`endif

  // FIFO state
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic              push;
  logic [EW-1:0]     push_entry;
  logic              do_push, do_pop;
  logic              empty, full;
  logic [EW-1:0]     head;

  logic [DIV_W-1:0]  div_eff;
  logic              cnt_expired;
  logic [BW-1:0]     last_idx;
  logic              start_edge;

  assign div_eff     = (i_baud_div < DIV_W'(4)) ? DIV_W'(4) : i_baud_div;
  assign cnt_expired = (cnt_q <= DIV_W'(1));
  assign last_idx    = BW'(DATA_W - 4) + BW'(nbits_q);
  assign start_edge  = rx_prev_q & ~rx_sync_q;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - DIV_W'(1) : cnt_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    pen_d      = pen_q;
    ohel_d     = ohel_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    push       = 1'b0;
    push_entry = {1'b0, perr_q, shift_q};
`ifdef UART_RX_BREAK_EN
    zero_d     = zero_q;
    brk_wait_d = brk_wait_q;
    brk        = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_START;
          cnt_d     = div_eff >> 1;
          div_d     = div_eff;
          nbits_d   = i_nbits;
          pen_d     = i_pen;
          ohel_d    = i_ohel;
          bit_idx_d = '0;
          shift_d   = '0;
          perr_d    = 1'b0;
`ifdef UART_RX_BREAK_EN
          zero_d    = 1'b1;
`endif
        end
      end

      ST_START: begin
        if (cnt_expired) begin
          if (!rx_sync_q) begin
            state_d = ST_DATA;
            cnt_d   = div_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_expired) begin
          shift_d[bit_idx_q] = rx_sync_q;
          cnt_d              = div_q;
`ifdef UART_RX_BREAK_EN
          zero_d             = zero_q & ~rx_sync_q;
`endif
          if (bit_idx_q == last_idx) begin
            state_d = pen_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (cnt_expired) begin
          // Unused high bits of shift_q stay 0, so they never disturb the XOR.
          perr_d  = ((^shift_q) ^ rx_sync_q) != ohel_q;
          cnt_d   = div_q;
          state_d = ST_STOP;
`ifdef UART_RX_BREAK_EN
          zero_d  = zero_q & ~rx_sync_q;
`endif
        end
      end

      ST_STOP: begin
`ifdef UART_RX_BREAK_EN
        if (brk_wait_q) begin
          // Leave only after the line has stayed high for a whole bit period.
          if (!rx_sync_q) begin
            cnt_d = div_q;
          end else if (cnt_expired) begin
            brk_wait_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end else if (cnt_expired) begin
          push       = 1'b1;
          push_entry = {~rx_sync_q, perr_q, shift_q};
          if (zero_q && !rx_sync_q) begin
            brk        = 1'b1;
            brk_wait_d = 1'b1;
            cnt_d      = div_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
`else
        if (cnt_expired) begin
          push       = 1'b1;
          push_entry = {~rx_sync_q, perr_q, shift_q};
          state_d    = ST_IDLE;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO control: a pop on the same cycle frees the slot a full-FIFO push needs.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = i_read & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    ovf_d    = ovf_q;
    if (push && full && !do_pop) begin
      ovf_d = 1'b1;
    end else if (i_clr) begin
      ovf_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(4);
      nbits_q    <= '0;
      pen_q      <= 1'b0;
      ohel_q     <= 1'b0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_q     <= 1'b0;
      brk_wait_q <= 1'b0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      pen_q      <= pen_d;
      ohel_q     <= ohel_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
`ifdef UART_RX_BREAK_EN
      zero_q     <= zero_d;
      brk_wait_q <= brk_wait_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

  // The head is masked while empty so outputs read 0 out of reset.
  assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign o_data  = head[DATA_W-1:0];
  assign o_perr  = head[DATA_W];
  assign o_ferr  = head[DATA_W+1];
  assign o_empty = empty;
  assign o_full  = full;
  assign o_ovf   = ovf_q;
  assign o_intr  = ~empty | ovf_q;
`ifdef UART_RX_BREAK_EN
  assign o_brk   = brk;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_engine.sv
// Directed bench for uart_rx_fifo_engine: frames are driven serially and each
// expected FIFO entry is queued at send time, then compared when popped.
module tb_uart_rx_fifo_engine;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 16;
  localparam int DIV    = 10;

  logic              clk;
  logic              i_rst;
  logic              i_rx;
  logic [DIV_W-1:0]  i_baud_div;
  logic [1:0]        i_nbits;
  logic              i_pen;
  logic              i_ohel;
  logic              i_read;
  logic              i_clr;
  logic [DATA_W-1:0] o_data;
  logic              o_perr;
  logic              o_ferr;
  logic              o_empty;
  logic              o_full;
  logic              o_ovf;
  logic              o_intr;

  typedef struct packed {
    logic              ferr;
    logic              perr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t sb[$];
  int     total = 0;
  int     bad   = 0;

  uart_rx_fifo_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .i_baud_div (i_baud_div),
    .i_nbits    (i_nbits),
    .i_pen      (i_pen),
    .i_ohel     (i_ohel),
    .i_read     (i_read),
    .i_clr      (i_clr),
    .o_data     (o_data),
    .o_perr     (o_perr),
    .o_ferr     (o_ferr),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_ovf      (o_ovf),
    .o_intr     (o_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Start bit, nb data bits LSB first, optional parity, stop; line left at stop value.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic par, input logic stp);
    i_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      i_rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    if (pen) begin
      i_rx = par;
      repeat (DIV) @(negedge clk);
    end
    i_rx = stp;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic expect_entry(input logic [7:0] d, input logic perr, input logic ferr);
    entry_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    if (sb.size() < DEPTH) sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    entry_t e;
    int     n;
    e = '0;
    n = 0;
    while (o_empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(o_empty), 32'(0));
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_data"}, 32'(o_data), 32'(e.data));
    check({tag, "_perr"}, 32'(o_perr), 32'(e.perr));
    check({tag, "_ferr"}, 32'(o_ferr), 32'(e.ferr));
    i_read = 1'b1;
    @(negedge clk);
    i_read = 1'b0;
  endtask

  initial begin
    i_rst      = 1'b1;
    i_rx       = 1'b1;
    i_baud_div = DIV_W'(DIV);
    i_nbits    = 2'd3;
    i_pen      = 1'b0;
    i_ohel     = 1'b0;
    i_read     = 1'b0;
    i_clr      = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_empty", 32'(o_empty), 32'(1));
    check("rst_full",  32'(o_full),  32'(0));
    check("rst_ovf",   32'(o_ovf),   32'(0));
    check("rst_intr",  32'(o_intr),  32'(0));
    check("rst_data",  32'(o_data),  32'(0));
    check("rst_perr",  32'(o_perr),  32'(0));
    check("rst_ferr",  32'(o_ferr),  32'(0));
    i_rst = 1'b0;
    idle(5);

    // Even parity, clean 8-bit frame
    i_nbits = 2'd3;
    i_pen   = 1'b1;
    i_ohel  = 1'b0;
    send_frame(8'h6A, 8, 1'b1, 1'b0, 1'b1);
    expect_entry(8'h6A, 1'b0, 1'b0);
    check("t1_empty", 32'(o_empty), 32'(0));
    check("t1_intr",  32'(o_intr),  32'(1));
    pop_check("t1");
    check("t1_empty_after_read", 32'(o_empty), 32'(1));
    check("t1_intr_after_read",  32'(o_intr),  32'(0));
    idle(5);

    // Parity error, then framing error, sent back-to-back
    send_frame(8'h6A, 8, 1'b1, 1'b1, 1'b1);
    expect_entry(8'h6A, 1'b1, 1'b0);
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b0);
    expect_entry(8'h55, 1'b0, 1'b1);
    idle(20);
    pop_check("t2a");
    pop_check("t2b");

    // Odd parity with an odd number of ones is clean
    i_ohel = 1'b1;
    send_frame(8'h07, 8, 1'b1, 1'b0, 1'b1);
    expect_entry(8'h07, 1'b0, 1'b0);
    idle(5);
    pop_check("t2c");

    // 5-bit frames, no parity, no idle gap
    i_nbits = 2'd0;
    i_pen   = 1'b0;
    i_ohel  = 1'b0;
    send_frame(8'h13, 5, 1'b0, 1'b0, 1'b1);
    expect_entry(8'h13, 1'b0, 1'b0);
    send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b1);
    expect_entry(8'h0A, 1'b0, 1'b0);
    idle(5);
    pop_check("t3a");
    pop_check("t3b");

    // Short glitch is a false start; a pop on empty is ignored
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("t4_no_push", 32'(o_empty), 32'(1));
    i_read = 1'b1;
    @(negedge clk);
    i_read = 1'b0;
    @(negedge clk);
    check("t4_pop_empty", 32'(o_empty), 32'(1));
    check("t4_full",      32'(o_full),  32'(0));
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1);
    expect_entry(8'h1F, 1'b0, 1'b0);
    idle(5);
    pop_check("t4_after");

    // Overflow: 17 frames into 16 entries, last one dropped
    i_nbits = 2'd3;
    for (int v = 0; v <= DEPTH; v++) begin
      send_frame(8'(v), 8, 1'b0, 1'b0, 1'b1);
      expect_entry(8'(v), 1'b0, 1'b0);
      idle(2);
    end
    check("t5_full", 32'(o_full), 32'(1));
    check("t5_ovf",  32'(o_ovf),  32'(1));
    check("t5_intr", 32'(o_intr), 32'(1));
    for (int i = 0; i < DEPTH; i++) begin
      pop_check($sformatf("t5_pop%0d", i));
    end
    @(negedge clk);
    check("t5_drained",     32'(o_empty), 32'(1));
    check("t5_ovf_sticky",  32'(o_ovf),   32'(1));
    check("t5_intr_sticky", 32'(o_intr),  32'(1));
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    check("t5_ovf_clr",  32'(o_ovf),  32'(0));
    check("t5_intr_clr", 32'(o_intr), 32'(0));

    // Reset in the middle of a data bit with three entries stored
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
    i_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    i_rx = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    check("t6_stored", 32'(o_empty), 32'(0));
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_empty", 32'(o_empty), 32'(1));
    check("t6_rst_ovf",   32'(o_ovf),   32'(0));
    check("t6_rst_intr",  32'(o_intr),  32'(0));
    check("t6_rst_data",  32'(o_data),  32'(0));
    sb.delete();
    i_rst = 1'b0;
    idle(20);
    check("t6_no_partial", 32'(o_empty), 32'(1));
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    expect_entry(8'hA5, 1'b0, 1'b0);
    idle(5);
    pop_check("t6_after");
    check("t6_final_empty", 32'(o_empty), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
